// File: rtl/shift32_r_iter.sv
// Iterative right shifter: one bit position per clock, START/DONE handshake,
// logical (zero-fill) or arithmetic (sign-fill) shifts.
module shift32_r_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   D,
  input  logic [SHAMT_W-1:0] S,
  input  logic               ARITH,
  output logic [WIDTH-1:0]   Y,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               fill_q;
  logic [WIDTH-1:0]   y_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            work_q  <= D;
            cnt_q   <= S;
            fill_q  <= ARITH & D[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // The count reaching zero costs one extra edge, so S=0 still takes two.
          if (cnt_q != '0) begin
            work_q <= {fill_q, work_q[WIDTH-1:1]};
            cnt_q  <= cnt_q - SHAMT_W'(1);
          end else begin
            y_q     <= work_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Y    = y_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shift32_r_iter.sv
// Directed-vector bench for shift32_r_iter: latency, fill modes, ignored
// START while busy, back-to-back starts and mid-operation reset.
module tb_shift32_r_iter;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] D;
  logic [4:0]  S;
  logic        ARITH;
  logic [31:0] Y;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  shift32_r_iter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .D(D), .S(S), .ARITH(ARITH),
    .Y(Y), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Starts an operation and runs until the DONE cycle; leaves time there.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic arith, input logic [31:0] exp, input bit poke);
    int busy_cycles;
    int guard;
    START = 1'b1; D = d; S = s; ARITH = arith;
    step();
    // Scramble operands after capture; they must not matter.
    START = 1'b0; D = 32'hDEADBEEF; S = 5'd7; ARITH = ~arith;
    busy_cycles = 0;
    guard = 0;
    while (!DONE && guard < 100) begin
      if (BUSY) busy_cycles++;
      if (poke && busy_cycles == 3) begin
        START = 1'b1; D = 32'hFFFFFFFF; S = 5'd1;
      end else begin
        START = 1'b0;
      end
      step();
      guard++;
    end
    START = 1'b0;
    check({tag, "_done"}, {31'd0, DONE}, 32'd1);
    check({tag, "_busycycles"}, busy_cycles, s + 32'd1);
    check({tag, "_y"}, Y, exp);
    check({tag, "_busy_in_done"}, {31'd0, BUSY}, 32'd0);
    $display("op %s D=%h S=%0d ARITH=%0d -> Y=%h busy=%0d", tag, d, s, arith, Y, busy_cycles);
  endtask

  task automatic finish_idle(input string tag, input logic [31:0] exp);
    START = 1'b0;
    step();
    check({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
    check({tag, "_y_hold"}, Y, exp);
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; D = '0; S = '0; ARITH = 1'b0;
    step();
    step();
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_y", Y, 32'd0);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_done", {31'd0, DONE}, 32'd0);
    end

    run_op("srl200_3", 32'd200, 5'd3, 1'b0, 32'd25, 1'b0);
    finish_idle("srl200_3", 32'd25);
    run_op("s0", 32'd1, 5'd0, 1'b0, 32'd1, 1'b0);
    finish_idle("s0", 32'd1);

    run_op("srl31", 32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0);
    finish_idle("srl31", 32'h00000001);
    run_op("sra31", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0);
    finish_idle("sra31", 32'hFFFFFFFF);
    run_op("sra4", 32'hF0000000, 5'd4, 1'b1, 32'hFF000000, 1'b0);
    finish_idle("sra4", 32'hFF000000);

    run_op("sra_pos_poke", 32'h7FFFFFFF, 5'd10, 1'b1, 32'h001FFFFF, 1'b1);
    finish_idle("sra_pos_poke", 32'h001FFFFF);

    // Back-to-back: second START issued in the first op's DONE cycle.
    run_op("b2b_first", 32'h000000C0, 5'd2, 1'b0, 32'h00000030, 1'b0);
    START = 1'b1; D = 32'h00000100; S = 5'd8; ARITH = 1'b0;
    check("b2b_first_y_valid", Y, 32'h00000030);
    check("b2b_first_done_valid", {31'd0, DONE}, 32'd1);
    run_op("b2b_second", 32'h00000100, 5'd8, 1'b0, 32'h00000001, 1'b0);
    finish_idle("b2b_second", 32'h00000001);

    // Reset partway through a 16-bit shift.
    START = 1'b1; D = 32'hFFFF0000; S = 5'd16; ARITH = 1'b0;
    step();
    START = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_busy_before_rst", {31'd0, BUSY}, 32'd1);
    RST = 1'b0;
    step();
    RST = 1'b1;
    check("mid_rst_y", Y, 32'd0);
    check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    check("mid_rst_done", {31'd0, DONE}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("mid_rst_no_done", {31'd0, DONE}, 32'd0);
    end
    $display("op mid_rst abandoned -> Y=%h BUSY=%0d", Y, BUSY);

    run_op("after_rst", 32'hFFFF0000, 5'd16, 1'b1, 32'hFFFFFFFF, 1'b0);
    finish_idle("after_rst", 32'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift32_r_iter.md
Name: shift32_r_iter

Overview:
- Iterative 32-bit right shifter; the sequential counterpart of the combinational left barrel shifter SHIFT32_L.
- Shifts one bit position per clock under a START/DONE handshake.
- Supports logical (zero-fill) and arithmetic (sign-fill) right shifts.
- Used by the ALU's multi-cycle path for SRL/SRA when area matters more than latency.

Parameters:
- WIDTH, 32, data width of D and Y.
- SHAMT_W, 5, shift-amount width; legal amounts are 0..2^SHAMT_W-1.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- D  input  WIDTH  operand; captured when START is accepted.
- S  input  SHAMT_W  shift amount; captured when START is accepted.
- ARITH  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured when START is accepted.
- Y  output  WIDTH  result; registered, holds until the next completion.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle completion pulse; Y is valid in that cycle.

Behaviour:
- Reset (RST=0 at a rising edge):
  - State goes to IDLE.
  - Y=0, BUSY=0, DONE=0; internal work register and counter cleared.
  - Reset overrides every other input.
- Internal state: work[WIDTH-1:0], cnt[SHAMT_W-1:0], fill bit, and a two-state FSM {IDLE, RUN}.
- IDLE with START=1 at edge E0:
  - work<=D, cnt<=S, fill<=ARITH & D[WIDTH-1].
  - State goes to RUN; BUSY=1 from the cycle after E0.
- IDLE with START=0: no change. DONE is 0 except in the single pulse cycle described below.
- RUN with cnt!=0:
  - work<={fill, work[WIDTH-1:1]}, cnt<=cnt-1.
  - Exactly one bit position per edge.
- RUN with cnt==0:
  - Y<=work, DONE<=1, BUSY<=0, state goes to IDLE.
  - DONE deasserts on the next edge unless another operation finishes on that edge; it cannot, because the minimum latency is 2.
- Latency:
  - DONE is high in the cycle following edge E0+S+1, i.e. S+2 edges after the START cycle begins.
  - BUSY is high for exactly S+1 cycles.
  - S=0 gives Y=D with DONE one edge after the first RUN edge.
- Operands and fill:
  - D, S and ARITH are don't-care after capture; changing them during RUN has no effect.
  - Fill bit is constant for the whole operation.
  - ARITH=1 with D[WIDTH-1]=0 behaves identically to logical.
- START handling:
  - START while BUSY=1 is ignored; no queueing, no error.
  - START=1 in the DONE cycle is accepted, since the FSM is already IDLE. Back-to-back operations therefore have zero idle gap, and Y/DONE from the first operation are still valid in that cycle.
- Reset mid-operation: the operation is abandoned, no DONE pulse, and Y returns to 0.
- Y changes only on a completion edge or on reset.
- No combinational path from inputs to outputs.

Test Plan:
- Reset with RST=0 for 2 cycles, then release, START=0 → Y=0, BUSY=0, DONE=0 for 5 cycles.
- D=200, S=3, ARITH=0 → BUSY for 4 cycles, then Y=25 with a single-cycle DONE; D=1, S=0 → Y=1 with BUSY for 1 cycle.
- D=0x80000000, S=31, ARITH=0 → Y=0x00000001 after BUSY for 32 cycles. Same operands with ARITH=1 → Y=0xFFFFFFFF. D=0xF0000000, S=4, ARITH=1 → Y=0xFF000000.
- D=0x7FFFFFFF, S=10, ARITH=1 → Y=0x001FFFFF (positive operand, zero-fill). During the run, drive START=1 with D=0xFFFFFFFF, S=1 → ignored; Y and timing unchanged.
- START asserted in the DONE cycle with D=0x00000100, S=8 → accepted; first Y stays valid in that cycle, second DONE follows 9 edges later with Y=0x00000001.
- D=0xFFFF0000, S=16 started, RST=0 after 5 cycles → no DONE, Y=0, BUSY=0. A fresh START after release then completes normally.
